// File: rtl/gray_wptr_gen.sv
// Write-side pointer generator for a Gray-pointer async FIFO: binary/Gray write
// pointer, two-flop read-pointer synchroniser, registered full/level/overflow.
module gray_wptr_gen #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_in,
    input  logic [ADDR_WIDTH:0]   rptr_gray_in,
    output logic [ADDR_WIDTH-1:0] waddr_out,
    output logic [ADDR_WIDTH:0]   wptr_gray_out,
    output logic                  full_out,
    output logic [ADDR_WIDTH:0]   level_out,
    output logic                  overflow_out
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0] rsync1_q, rsync2_q;
    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic          full_q, full_d;
    logic [PW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rbin;
    logic          accept;

    always_comb begin
        rbin    = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rsync2_q >> i);
        end
        accept  = inc_in & ~full_q;
        wbin_d  = wbin_q + PW'(accept);
        wgray_d = wbin_d ^ (wbin_d >> 1);
        full_d  = (wgray_d == (rsync2_q ^ FULL_MASK));
        level_d = wbin_d - rbin;
        ovf_d   = inc_in & full_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsync1_q <= '0;
            rsync2_q <= '0;
            wbin_q   <= '0;
            wgray_q  <= '0;
            full_q   <= 1'b0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rsync1_q <= rptr_gray_in;
            rsync2_q <= rsync1_q;
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            full_q   <= full_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    assign waddr_out     = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray_out = wgray_q;
    assign full_out      = full_q;
    assign level_out     = level_q;
    assign overflow_out  = ovf_q;

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Scoreboard bench for gray_wptr_gen: the model tracks write count and delayed read
// pointer as integers; full/level come from their modular difference.
module tb_gray_wptr_gen;

    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inc_in;
    logic [PW-1:0] rptr_gray_in;
    logic [AW-1:0] waddr_out;
    logic [PW-1:0] wptr_gray_out;
    logic          full_out;
    logic [PW-1:0] level_out;
    logic          overflow_out;

    gray_wptr_gen #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_in       (inc_in),
        .rptr_gray_in (rptr_gray_in),
        .waddr_out    (waddr_out),
        .wptr_gray_out(wptr_gray_out),
        .full_out     (full_out),
        .level_out    (level_out),
        .overflow_out (overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int waddr;
        int wgray;
        int full;
        int level;
        int ovf;
        bit in_rst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: writes committed (mod 32), full, and read pointer history.
    int m_w = 0;
    int m_full = 0;
    int s1 = 0;
    int s2 = 0;
    int r = 0;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle at the falling edge and push what the next rising edge must show.
    task automatic cycle(input bit rst_v, input bit inc_v, input int r_v);
        exp_t e;
        int   acc, wn, d;
        @(negedge clk);
        rst_n        = rst_v;
        inc_in       = inc_v;
        rptr_gray_in = PW'(gray(r_v));
        if (!rst_v) begin
            e = '{0, 0, 0, 0, 0, 1'b1};
            m_w = 0; m_full = 0; s1 = 0; s2 = 0;
        end else begin
            acc     = (inc_v && m_full == 0) ? 1 : 0;
            wn      = (m_w + acc) % 32;
            d       = (wn - s2 + 32) % 32;
            e.waddr = wn % 16;
            e.wgray = gray(wn);
            e.full  = (d == 16) ? 1 : 0;
            e.level = d;
            e.ovf   = (inc_v && m_full == 1) ? 1 : 0;
            e.in_rst = 1'b0;
            m_w = wn; m_full = e.full;
            s2 = s1; s1 = r_v;
        end
        exp_q.push_back(e);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expectation per rising edge and compares.
    initial begin : monitor
        exp_t e;
        int   prev_g = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("waddr", int'(waddr_out), e.waddr);
                check("wgray", int'(wptr_gray_out), e.wgray);
                check("full", int'(full_out), e.full);
                check("level", int'(level_out), e.level);
                check("ovf", int'(overflow_out), e.ovf);
                if (!e.in_rst)
                    check("gray_step_le1", ($countones(PW'(prev_g) ^ wptr_gray_out) <= 1) ? 1 : 0, 1);
                prev_g = int'(wptr_gray_out);
            end
        end
    end

    initial begin : stim
        int hist[$];
        bit saw_wrap;
        int pg;
        rst_n = 1'b1; inc_in = 1'b0; rptr_gray_in = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_waddr", int'(waddr_out), 0);
        check("rst_wgray", int'(wptr_gray_out), 0);
        check("rst_full", int'(full_out), 0);
        check("rst_level", int'(level_out), 0);
        check("rst_ovf", int'(overflow_out), 0);

        // Reset held with random inputs, then release and idle.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'($urandom_range(1)), int'($urandom_range(31)));
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);

        // Fill to full.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 0);
        sample();
        check("fill_wgray", int'(wptr_gray_out), 'h18);
        check("fill_full", int'(full_out), 1);
        check("fill_level", int'(level_out), 16);

        // Overflow while full.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 0);
            sample();
            check("ovf_pulse", int'(overflow_out), 1);
            check("ovf_hold_wgray", int'(wptr_gray_out), 'h18);
        end

        // Drain one entry with writes still requested.
        cycle(1'b1, 1'b1, 1);
        sample();
        check("drain_e0_full", int'(full_out), 1);
        cycle(1'b1, 1'b1, 1);
        sample();
        check("drain_e1_full", int'(full_out), 1);
        cycle(1'b1, 1'b1, 1);
        sample();
        check("drain_e2_full", int'(full_out), 0);
        check("drain_e2_level", int'(level_out), 15);
        check("drain_e2_ovf", int'(overflow_out), 1);
        cycle(1'b1, 1'b1, 1);
        sample();
        check("drain_e3_wgray", int'(wptr_gray_out), 'h19);
        check("drain_e3_full", int'(full_out), 1);

        // Catch reader up to writer.
        r = 1;
        while (r != m_w) begin
            r = (r + 1) % 32;
            cycle(1'b1, 1'b0, r);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, r);

        // Wrap: reader trails the writer by 4 cycles.
        for (int i = 0; i < 4; i++) hist.push_back(m_w);
        saw_wrap = 1'b0;
        pg = int'(wptr_gray_out);
        for (int i = 0; i < 40; i++) begin
            hist.push_back(m_w);
            r = hist.pop_front();
            cycle(1'b1, 1'b1, r);
            sample();
            check("wrap_not_full", int'(full_out), 0);
            if (pg == 'h10 && wptr_gray_out == '0) saw_wrap = 1'b1;
            pg = int'(wptr_gray_out);
        end
        check("wrap_seen_0x10_to_0", int'(saw_wrap), 1);
        r = hist[hist.size()-1];

        // Random traffic: reader advances only over written entries.
        for (int i = 0; i < 300; i++) begin
            if (((m_w - r + 32) % 32) != 0 && $urandom_range(2) == 0) r = (r + 1) % 32;
            cycle(1'b1, 1'($urandom_range(1)), r);
        end

        // Settle at level 9, then reset asynchronously between edges.
        while (r != m_w) begin
            r = (r + 1) % 32;
            cycle(1'b1, 1'b0, r);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, r);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, r);
        sample();
        check("pre_rst_level", int'(level_out), 9);
        rst_n = 1'b0;
        #1;
        check("arst_waddr", int'(waddr_out), 0);
        check("arst_wgray", int'(wptr_gray_out), 0);
        check("arst_full", int'(full_out), 0);
        check("arst_level", int'(level_out), 0);
        check("arst_ovf", int'(overflow_out), 0);
        m_w = 0; m_full = 0; s1 = 0; s2 = 0;
        r = 0;
        cycle(1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 0);
        sample();
        check("post_rst_first_wgray", int'(wptr_gray_out), 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);

        sample();
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
